// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: owns the fetch PC, keeps at most one instruction-memory
// request in flight, and buffers {pc, instruction} pairs in a DEPTH-entry
// queue that decode drains over a valid/ready handshake. Redirects from
// execute are turned into a target here; every redirect flushes the queue.
// Optional build macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect target
// raises fetch_trap/trap_pc and stops fetching; without it the target's low
// two bits are cleared and fetching carries on.
module fetch_queue_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ins,
  output logic [31:0] out_pc,
  output logic [31:0] nextpc,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        fetch_trap,
  output logic [31:0] trap_pc,
`endif
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  input  logic        redir_branch,
  input  logic        redir_jump,
  input  logic        redir_jr,
  input  logic [15:0] redir_imm16,
  input  logic [25:0] redir_index,
  input  logic [31:0] redir_regpc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   fetch_pc_reg;
  logic [31:0]   pend_pc_reg;
  logic          outstanding_reg;
  logic          drop_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_after_pop;
  logic [CW-1:0] count_next;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] rd_ptr_next;
  logic [PW-1:0] wr_ptr_reg;
  logic [31:0]   out_pc_reg;
  logic [31:0]   out_ins_reg;

  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   ins_mem [DEPTH];

  logic [31:0]   pc_plus4;
  logic [31:0]   target_raw;
  logic [31:0]   target;
  logic          redirect;
  logic          grant;
  logic          rsp;
  logic          push;
  logic          pop;
  logic          fetch_block;

  // Resolve the control-transfer target; jr outranks jump outranks branch
  always_comb begin
    pc_plus4   = redir_pc + 32'd4;
    target_raw = pc_plus4 + {{14{redir_imm16[15]}}, redir_imm16, 2'b00};
    if (redir_jr) begin
      target_raw = redir_regpc;
    end else if (redir_jump) begin
      target_raw = {pc_plus4[31:28], redir_index, 2'b00};
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        trap_reg;
  logic [31:0] trap_pc_reg;

  assign target      = target_raw;
  assign fetch_block = trap_reg;
  assign fetch_trap  = trap_reg;
  assign trap_pc     = trap_pc_reg;

  // Latch a misaligned redirect target; only a later aligned redirect or reset clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      trap_reg    <= 1'b0;
      trap_pc_reg <= 32'h0;
    end else if (redirect) begin
      trap_reg <= (target_raw[1:0] != 2'b00);
      if (target_raw[1:0] != 2'b00) begin
        trap_pc_reg <= target_raw;
      end
    end
  end
`else
  assign target      = target_raw & 32'hFFFF_FFFC;
  assign fetch_block = 1'b0;
`endif

  // A redirect needs at least one select; redir_valid alone does nothing.
  // The request is gated by reset directly so it is low during reset and
  // rises in the very first cycle reset is released.
  assign redirect  = redir_valid & (redir_jr | redir_jump | redir_branch);
  assign imem_req  = ~reset & ~outstanding_reg & (count_reg < DEPTH_C) & ~fetch_block;
  assign imem_addr = fetch_pc_reg;
  assign grant     = imem_req & imem_gnt;
  assign rsp       = imem_rvalid & outstanding_reg;
  assign push      = rsp & ~drop_reg & ~redirect;
  assign out_valid = (count_reg != '0);
  assign pop       = out_valid & out_ready;
  assign out_pc    = out_pc_reg;
  assign out_ins   = out_ins_reg;
  assign nextpc    = out_pc_reg + 32'd4;

  // Queue occupancy and head pointer after this cycle's pop and push.
  // A request is only issued with a free slot, so count never exceeds DEPTH.
  always_comb begin
    count_after_pop = count_reg - CW'(pop);
    count_next      = count_after_pop + CW'(push);
    rd_ptr_next     = pop ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
  end

  // Fetch PC, single outstanding request tracking and stale-response drop flag
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      pend_pc_reg     <= 32'h0;
      outstanding_reg <= 1'b0;
      drop_reg        <= 1'b0;
    end else begin
      if (grant) begin
        fetch_pc_reg    <= fetch_pc_reg + 32'd4;
        pend_pc_reg     <= fetch_pc_reg;
        outstanding_reg <= 1'b1;
      end else if (rsp) begin
        outstanding_reg <= 1'b0;
      end
      if (redirect) begin
        fetch_pc_reg <= target;
        // Anything granted but not yet answered belongs to the old path
        drop_reg     <= grant | (outstanding_reg & ~imem_rvalid);
      end else if (rsp) begin
        drop_reg <= 1'b0;
      end
    end
  end

  // Queue pointers, count and the registered head view; the head holds when empty
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg   <= '0;
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      out_pc_reg  <= 32'h0;
      out_ins_reg <= 32'h0;
    end else if (redirect) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else begin
      count_reg  <= count_next;
      rd_ptr_reg <= rd_ptr_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (count_after_pop != '0) begin
        out_pc_reg  <= pc_mem[rd_ptr_next];
        out_ins_reg <= ins_mem[rd_ptr_next];
      end else if (push) begin
        // Queue would otherwise be empty: the arriving word becomes the head
        out_pc_reg  <= pend_pc_reg;
        out_ins_reg <= imem_rdata;
      end
    end
  end

  // Queue storage write port
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]  <= pend_pc_reg;
      ins_mem[wr_ptr_reg] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: a small instruction-memory model
// answers grants, expected {pc, ins} pairs are queued as responses are driven
// and compared as decode pops them.
module tb_fetch_queue_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        out_valid, out_ready;
  logic [31:0] out_ins, out_pc, nextpc;
  logic        redir_valid, redir_branch, redir_jump, redir_jr;
  logic [31:0] redir_pc, redir_regpc;
  logic [15:0] redir_imm16;
  logic [25:0] redir_index;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_trap;
  logic [31:0] trap_pc;
`endif

  fetch_queue_unit #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_ins(out_ins),
    .out_pc(out_pc), .nextpc(nextpc),
`ifdef FETCH_MISALIGN_TRAP_EN
    .fetch_trap(fetch_trap), .trap_pc(trap_pc),
`endif
    .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_branch(redir_branch),
    .redir_jump(redir_jump), .redir_jr(redir_jr), .redir_imm16(redir_imm16),
    .redir_index(redir_index), .redir_regpc(redir_regpc)
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } entry_t;
  entry_t exp_q[$];

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] exp_fetch_pc = RESET_PC;
  logic [31:0] pend_addr    = 32'h0;
  logic [31:0] last_pop_pc  = 32'h0;
  logic [31:0] last_exp_pc  = 32'h0;
  logic [31:0] watched_addr = 32'h0;
  bit          pend_valid, pend_stale, corrupt_next, seen_bad, watch_grant;
  bit          gnt_en, ready_en;
  int          pend_wait = 0;
  int          lat       = 1;
  int          pops      = 0;

  bit          r_branch, r_jump, r_jr;
  logic [31:0] r_pc = 32'h0, r_regpc = 32'h0, r_target = 32'h0;
  logic [15:0] r_imm = 16'h0;
  logic [25:0] r_idx = 26'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // One clock cycle: drive inputs at the falling edge, run memory model and scoreboard
  task automatic step(input bit do_redir);
    bit          resp, grant, eff;
    logic [31:0] rdata;
    entry_t      e;
    eff          = do_redir && (r_branch || r_jump || r_jr);
    out_ready    = ready_en;
    imem_gnt     = gnt_en;
    resp         = !reset && pend_valid && (pend_wait == 0);
    rdata        = corrupt_next ? 32'hDEAD_BEEF : mem_word(pend_addr);
    imem_rvalid  = resp;
    imem_rdata   = resp ? rdata : 32'h0;
    redir_valid  = do_redir;
    redir_branch = r_branch;
    redir_jump   = r_jump;
    redir_jr     = r_jr;
    redir_pc     = r_pc;
    redir_imm16  = r_imm;
    redir_index  = r_idx;
    redir_regpc  = r_regpc;
    #1;
    if (reset) begin
      exp_q.delete();
      pend_valid   = 0;
      corrupt_next = 0;
      exp_fetch_pc = RESET_PC;
    end else begin
      if (out_valid && out_ready) begin
        pops++;
        last_pop_pc = out_pc;
        if (out_ins == 32'hDEAD_BEEF) seen_bad = 1;
        $display("[TB] pop pc=%h ins=%h nextpc=%h", out_pc, out_ins, nextpc);
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          last_exp_pc = e.pc;
          check("out_pc", out_pc, e.pc);
          check("out_ins", out_ins, e.ins);
          check("nextpc", nextpc, e.pc + 32'd4);
        end
      end
      grant = imem_req && imem_gnt;
      if (pend_valid) check("req_while_pending", 32'(imem_req), 32'd0);
      if (grant) begin
        check("imem_addr", imem_addr, exp_fetch_pc);
        if (watch_grant) begin
          watched_addr = imem_addr;
          watch_grant  = 0;
        end
      end
      if (resp) begin
        pend_valid   = 0;
        corrupt_next = 0;
        if (!pend_stale && !eff) exp_q.push_back({pend_addr, rdata});
      end else if (pend_valid) begin
        pend_wait--;
      end
      if (eff && pend_valid) pend_stale = 1;
      if (grant) begin
        pend_valid   = 1;
        pend_addr    = imem_addr;
        pend_wait    = lat - 1;
        pend_stale   = eff;
        exp_fetch_pc = exp_fetch_pc + 32'd4;
      end
      if (eff) begin
        exp_q.delete();
        exp_fetch_pc = r_target;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic redirect(input bit b, input bit j, input bit jr, input logic [31:0] pc,
                          input logic [15:0] imm, input logic [25:0] idx,
                          input logic [31:0] regpc, input logic [31:0] tgt);
    r_branch = b;  r_jump = j;  r_jr = jr;
    r_pc = pc;  r_imm = imm;  r_idx = idx;  r_regpc = regpc;  r_target = tgt;
    step(1);
    r_branch = 0;  r_jump = 0;  r_jr = 0;
  endtask

  task automatic wait_pops(input int n, input int budget);
    int start;
    int k;
    start = pops;
    k = 0;
    while ((pops - start) < n && k < budget) begin
      step(0);
      k++;
    end
    if ((pops - start) < n) check("pop_timeout", 32'(pops - start), 32'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_req"}, 32'(imem_req), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_ins"}, out_ins, 32'h0);
    check({tag, "_out_pc"}, out_pc, 32'h0);
    check({tag, "_nextpc"}, nextpc, 32'h4);
`ifdef FETCH_MISALIGN_TRAP_EN
    check({tag, "_fetch_trap"}, 32'(fetch_trap), 32'd0);
    check({tag, "_trap_pc"}, trap_pc, 32'h0);
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int start;
    reset = 1'b1;
    imem_gnt = 1'b0;  imem_rvalid = 1'b0;  imem_rdata = 32'h0;  out_ready = 1'b0;
    redir_valid = 1'b0;  redir_branch = 1'b0;  redir_jump = 1'b0;  redir_jr = 1'b0;
    redir_pc = 32'h0;  redir_imm16 = 16'h0;  redir_index = 26'h0;  redir_regpc = 32'h0;
    gnt_en = 1;  ready_en = 1;  lat = 1;
    @(negedge clk);
    step(0);
    step(0);
    check_reset_outputs("reset");

    // First cycle out of reset requests RESET_PC
    reset = 1'b0;
    #1;
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, RESET_PC);

    // Streaming: 0x3000, 0x3004, 0x3008
    wait_pops(3, 30);
    check("seq_third_pc", last_pop_pc, 32'h0000_3008);

    // Back-pressure: fill to DEPTH, then drain in order
    ready_en = 0;
    repeat (20) step(0);
    check("full_req", 32'(imem_req), 32'd0);
    check("full_valid", 32'(out_valid), 32'd1);
    check("full_entries", 32'(exp_q.size()), 32'd4);
    gnt_en = 0;
    ready_en = 1;
    start = pops;
    k = 0;
    while (exp_q.size() > 0 && k < 20) begin
      step(0);
      k++;
    end
    check("drain_count", 32'(pops - start), 32'd4);
    check("empty_valid", 32'(out_valid), 32'd0);
    check("empty_hold_pc", out_pc, last_exp_pc);

    // Backward branch: 0x3008 + 4 - 8 = 0x3004
    gnt_en = 1;
    repeat (5) step(0);
    redirect(1, 0, 0, 32'h0000_3008, 16'hFFFE, 26'h0, 32'h0, 32'h0000_3004);
    wait_pops(1, 20);
    check("branch_pop_pc", last_pop_pc, 32'h0000_3004);

    // redir_valid with no select leaves the stream untouched
    redirect(0, 0, 0, 32'h0000_5000, 16'h0010, 26'h0, 32'h0000_7000, 32'h0);
    wait_pops(2, 20);

    // Redirect with a request in flight: its (poisoned) data must vanish
    lat = 3;
    k = 0;
    while (!(pend_valid && !pend_stale) && k < 20) begin
      step(0);
      k++;
    end
    corrupt_next = 1;
    redirect(0, 0, 1, 32'h0000_3010, 16'h0, 26'h0, 32'h0000_3100, 32'h0000_3100);
    watch_grant = 1;
    wait_pops(2, 40);
    check("deadbeef_dropped", 32'(seen_bad), 32'd0);
    check("redir_first_addr", watched_addr, 32'h0000_3100);
    lat = 1;

    // jr wins over jump
    redirect(0, 1, 1, 32'h0000_3000, 16'h0, 26'h3FF_FFFF, 32'h0040_0000, 32'h0040_0000);
    wait_pops(1, 20);
    check("jr_over_jump_pc", last_pop_pc, 32'h0040_0000);

    // Jump alone keeps the upper nibble of pc+4
    redirect(0, 1, 0, 32'hA000_0000, 16'h0, 26'h000_0100, 32'h0, 32'hA000_0400);
    wait_pops(1, 20);
    check("jump_pop_pc", last_pop_pc, 32'hA000_0400);

    // Misaligned jr target
`ifdef FETCH_MISALIGN_TRAP_EN
    redirect(0, 0, 1, 32'h0000_3000, 16'h0, 26'h0, 32'h0000_3002, 32'h0000_3002);
    repeat (6) step(0);
    check("trap_set", 32'(fetch_trap), 32'd1);
    check("trap_pc", trap_pc, 32'h0000_3002);
    check("trap_no_req", 32'(imem_req), 32'd0);
    redirect(0, 0, 1, 32'h0000_3000, 16'h0, 26'h0, 32'h0000_3200, 32'h0000_3200);
    wait_pops(1, 20);
    check("trap_cleared", 32'(fetch_trap), 32'd0);
    check("after_trap_pc", last_pop_pc, 32'h0000_3200);
`else
    redirect(0, 0, 1, 32'h0000_3000, 16'h0, 26'h0, 32'h0000_3002, 32'h0000_3000);
    wait_pops(1, 20);
    check("misalign_forced_pc", last_pop_pc, 32'h0000_3000);
`endif

    // Reset in the middle of traffic
    repeat (3) step(0);
    reset = 1'b1;
    step(0);
    check_reset_outputs("midreset");
    reset = 1'b0;
    wait_pops(1, 20);
    check("restart_pc", last_pop_pc, RESET_PC);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
